// File: rtl/data_fifo_pkg.sv
// Shared defaults and helpers for the data_fifo block.
package data_fifo_pkg;

  localparam int unsigned DATA_FIFO_WIDTH = 16;
  localparam int unsigned DATA_FIFO_DEPTH = 16;

  // Default almost-full threshold: two entries of headroom below full.
  function automatic int unsigned afull_default(input int unsigned depth);
    return depth - 2;
  endfunction

endpackage : data_fifo_pkg

// File: rtl/data_fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register file, synchronous write, combinational read.
module fifo_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : fifo_mem

// File: rtl/data_fifo.sv
// data_fifo: single-clock FIFO with registered pop port, occupancy and sticky error flags.
module data_fifo
  import data_fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = DATA_FIFO_WIDTH,
  parameter int unsigned DEPTH       = DATA_FIFO_DEPTH,
  parameter int unsigned AFULL_LEVEL = afull_default(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   w_en,
  input  logic [WIDTH-1:0]       w_data,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   r_en,
  output logic [WIDTH-1:0]       r_data,
  output logic                   r_valid,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_overflow;
  logic             r_underflow;

  logic [PW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_mem_we;
  logic [WIDTH-1:0] w_rd_word;

  // Status is decoded from the registered pointers only.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Requests that hit a full/empty FIFO are simply dropped.
  assign w_push   = w_en & ~w_full;
  assign w_pop    = r_en & ~w_empty;
  assign w_mem_we = w_push & ~clear;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_word)
  );

  // Read/write pointers with wrap bit; clear flushes both.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Sticky error flags, cleared only by clear or reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_en && w_full)  r_overflow  <= 1'b1;
      if (r_en && w_empty) r_underflow <= 1'b1;
    end
  end

  // Registered pop port; r_data holds its value unless a pop is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (clear) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) r_data <= w_rd_word;
    end
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = w_count;
  assign almost_full = (w_count >= PW'(AFULL_LEVEL));
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule : data_fifo

// File: tb/tb_data_fifo.sv
// Scoreboard bench for data_fifo: directed scenarios plus randomized traffic vs a queue model.
module tb_data_fifo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFULL = DEPTH - 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rstn;
  logic             clear;
  logic             w_en;
  logic [WIDTH-1:0] w_data;
  logic             full;
  logic             almost_full;
  logic             r_en;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  data_fifo #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (clear),
    .w_en        (w_en),
    .w_data      (w_data),
    .full        (full),
    .almost_full (almost_full),
    .r_en        (r_en),
    .r_data      (r_data),
    .r_valid     (r_valid),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue plus flag/output state.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] sb_q[$];
  logic             m_ovf;
  logic             m_unf;
  logic             m_rvalid;
  logic [WIDTH-1:0] m_rdata;

  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFULL));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("r_valid", 32'(r_valid), 32'(m_rvalid));
    chk("r_data", 32'(r_data), 32'(m_rdata));
  endtask

  // Drive one clock of requests and advance the model to the post-edge state.
  task automatic cycle(input logic we, input logic [WIDTH-1:0] wd, input logic re, input logic clr);
    logic was_full;
    logic was_empty;
    logic [WIDTH-1:0] d;
    @(negedge clk);
    w_en   = we;
    w_data = wd;
    r_en   = re;
    clear  = clr;
    if (clr) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      m_rvalid = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (we && was_full)  m_ovf = 1'b1;
      if (re && was_empty) m_unf = 1'b1;
      m_rvalid = 1'b0;
      if (re && !was_empty) begin
        d = mq.pop_front();
        sb_q.push_back(d);
        m_rdata  = d;
        m_rvalid = 1'b1;
      end
      if (we && !was_full) mq.push_back(wd);
    end
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge.
  task automatic async_reset();
    #2;
    rstn  = 1'b0;
    w_en  = 1'b0;
    r_en  = 1'b0;
    clear = 1'b0;
    mq.delete();
    sb_q.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);
    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_r_data", 32'(r_data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: after every active edge compare status and pop the scoreboard on r_valid.
  initial begin
    logic [WIDTH-1:0] exp_d;
    forever begin
      @(posedge clk);
      #1;
      check_status();
      if (r_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_pop", 32'(r_data), 32'hFFFF_FFFF);
        end else begin
          exp_d = sb_q.pop_front();
          chk("sb_data", 32'(r_data), 32'(exp_d));
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    rstn   = 1'b1;
    clear  = 1'b0;
    w_en   = 1'b0;
    r_en   = 1'b0;
    w_data = '0;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Fill from reset with 1..16, one extra push while full, then drain.
    for (int i = 1; i <= 16; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
    cycle(1'b1, 16'h5555, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Pop on empty with simultaneous push; next pop returns that word.
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Half occupancy then 40 cycles of simultaneous push and pop.
    for (int i = 0; i < 8; i++) cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, WIDTH'($urandom), 1'b1, 1'b0);

    // Fill to full, then push 0xAAAA together with a pop.
    while (mq.size() < DEPTH) cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 16'hAAAA, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Reset mid-stream, then clear with 5 entries and a concurrent push.
    cycle(1'b1, 16'h1234, 1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 16'hC1EA, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic with occasional clear and asynchronous reset.
    for (int i = 0; i < 800; i++) begin
      int unsigned mode;
      int unsigned pw;
      int unsigned pr;
      mode = (i / 100) % 4;
      pw = (mode == 0) ? 80 : (mode == 1) ? 30 : 55;
      pr = (mode == 0) ? 30 : (mode == 1) ? 80 : 55;
      cycle(1'($urandom_range(99) < pw), WIDTH'($urandom), 1'($urandom_range(99) < pr),
            1'($urandom_range(99) < 2));
      if ($urandom_range(199) == 0) async_reset();
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule : tb_data_fifo

// File: doc/data_fifo.md
# data_fifo

Synchronous single-clock FIFO that sits directly downstream of `fifo_supplier`. It accepts the supplier's `w_en`/`to_fifo` stream and returns `full` to throttle it. On the read side it serves the systolic-array input stage with a registered pop interface. It also provides occupancy and sticky error flags for debug and flow control.

## Interface
- `WIDTH`, 16, data word width; must match the supplier's `WIDTH`.
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `AFULL_LEVEL`, `DEPTH-2`, occupancy at or above which `almost_full` asserts; range 1..DEPTH.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `clear`  in  1  synchronous flush.
- `w_en`  in  1  push request.
- `w_data`  in  WIDTH  push data.
- `full`  out  1  occupancy == DEPTH.
- `almost_full`  out  1  occupancy ≥ AFULL_LEVEL.
- `r_en`  in  1  pop request.
- `r_data`  out  WIDTH  popped word, registered.
- `r_valid`  out  1  `r_data` updated this cycle.
- `empty`  out  1  occupancy == 0.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a push was attempted while full.
- `underflow`  out  1  sticky: a pop was attempted while empty.

## Operation
- Pointers:
  - `wr_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits wide; the extra MSB is a wrap bit.
  - The storage index is the pointer's low bits; pointers wrap naturally modulo 2·DEPTH.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - `count` = `wr_ptr - rd_ptr`, computed modulo 2^($clog2(DEPTH)+1).
- Push is accepted iff `w_en & ~full`. The word is stored at `wr_ptr` and `wr_ptr` increments.
- Pop is accepted iff `r_en & ~empty`. `r_data` ← mem[`rd_ptr`], `rd_ptr` increments, and `r_valid` is 1 in the following cycle.
- Simultaneous push and pop:
  - Neither full nor empty: both are accepted and `count` is unchanged.
  - Full: the pop is accepted, the push is rejected, and `overflow` sets. There is no write-through.
  - Empty: the push is accepted, the pop is rejected, and `underflow` sets. There is no fall-through; the word is readable next cycle.
- Rejected requests do not change pointers or storage.
- `r_data` holds its last value when no pop is accepted.
- `clear` has priority over `w_en` and `r_en`. It zeroes both pointers and both sticky flags and forces `r_valid` to 0 next cycle. Storage contents and `r_data` are untouched.
- Asynchronous reset:
  - Applies immediately, including mid-transfer.
  - Pointers reset to 0 and any in-flight word is discarded.
  - Reset values: `r_data` 0, `r_valid` 0, `overflow` 0, `underflow` 0.
  - Resulting status: `empty` 1, `full` 0, `almost_full` 0 (since AFULL_LEVEL ≥ 1), `count` 0.

## Timing
- `full`, `empty`, `almost_full` and `count` are decoded from registered pointers only. There is no combinational path from `w_en` or `r_en` to any output.
- Push-to-visible latency: a word pushed at edge N raises occupancy after edge N. It is poppable at edge N+1 and appears on `r_data` after that edge.
- Pop latency is 1 cycle: `r_en` sampled at edge N gives `r_data`/`r_valid` after edge N.
- `full` rises in the cycle after the DEPTH-th unmatched push. It falls in the cycle after the first accepted pop.
- Sustained throughput is one push and one pop per cycle.
- Sticky flags set on the edge where the illegal request is sampled. They clear only on `clear` or reset.

## Structure
- The `ADDR_WIDTH` define and any shared FIFO status struct (full/empty/count) belong in the common TPU package/defines file. This block introduces no new typedefs there.
- One sub-module, `fifo_mem`: a 1-write/1-read register-file array, DEPTH×WIDTH, with synchronous write and combinational read, indexed by pointer low bits.
- The top level holds the pointers, flags and the output register.

## Test plan
- Fill from reset with DEPTH=16, pushing 0x0001..0x0010 → `full`=1 after the 16th edge and `count`=16; `almost_full`=1 from `count`=14 on.
- A 17th push while full → storage unchanged, `overflow`=1 and sticky. Draining then yields 0x0001..0x0010 in order, with `r_valid` pulsed each cycle.
- Pop while empty with simultaneous push of 0xBEEF → `underflow`=1, `r_valid`=0, `count`=1; the next pop returns 0xBEEF.
- Continuous push+pop for 40 cycles at half occupancy → both pointers wrap at least twice, `count` stays constant, and data order is preserved.
- Full FIFO with simultaneous push 0xAAAA and pop → oldest word returned, push rejected, `overflow`=1, `count`=15.
- `rstn` asserted asynchronously mid-stream, then `clear` asserted with 5 entries → both give `empty`=1, `count`=0, flags 0, `r_valid`=0; `clear` wins over a concurrent `w_en`.
